// File: rtl/tfp401a_pkg.sv
`default_nettype none
// ============================================================================
// tfp401a_pkg: lock-state encodings, default window lengths, saturating helper
// Revision: 1.0
// ============================================================================
package tfp401a_pkg;

    localparam logic [1:0] LOST   = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int ACQ_WIN_DEFAULT  = 1600;
    localparam int HOLD_WIN_DEFAULT = 1000000;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tfp401a_rx_lock_video_geom_meas.sv
`default_nettype none
// ============================================================================
// video_geom_meas: active width/height and line-period counters, frame match
// Revision: 1.0
// ============================================================================
module video_geom_meas
    import tfp401a_pkg::*;
#(
    parameter int MEAS_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_de,
    input  logic              i_de_rise,
    input  logic              i_de_fall,
    input  logic              i_vs_rise,
    output logic [MEAS_W-1:0] o_h_active,
    output logic [MEAS_W-1:0] o_v_active,
    output logic [MEAS_W-1:0] o_h_total,
    output logic              o_meas_valid,
    output logic              o_match
);
    localparam logic [MEAS_W-1:0] c_MAX = '1;
    localparam logic [MEAS_W-1:0] c_ONE = MEAS_W'(1);

    logic [MEAS_W-1:0] r_h_cnt, r_hp_cnt, r_line_cnt, r_h_line;
    logic [MEAS_W-1:0] r_h_active, r_v_active, r_h_total;
    logic              r_meas_valid;
    logic [MEAS_W-1:0] w_h_cnt_inc, w_hp_cnt_inc, w_line_cnt_inc;

    assign w_h_cnt_inc    = MEAS_W'(sat_inc(32'(r_h_cnt), 32'(c_MAX)));
    assign w_hp_cnt_inc   = MEAS_W'(sat_inc(32'(r_hp_cnt), 32'(c_MAX)));
    assign w_line_cnt_inc = MEAS_W'(sat_inc(32'(r_line_cnt), 32'(c_MAX)));

    // Rising-edge cycle is itself counted, so a 64-cycle DE pulse reads 64.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_h_cnt      <= '0;
            r_hp_cnt     <= '0;
            r_line_cnt   <= '0;
            r_h_line     <= '0;
            r_h_active   <= '0;
            r_v_active   <= '0;
            r_h_total    <= '0;
            r_meas_valid <= 1'b0;
        end else begin
            r_meas_valid <= i_vs_rise;
            if (i_de_rise)
                r_h_cnt <= c_ONE;
            else if (i_de)
                r_h_cnt <= w_h_cnt_inc;
            if (i_de_fall)
                r_h_line <= r_h_cnt;
            if (i_de_rise) begin
                r_h_total <= r_hp_cnt;
                r_hp_cnt  <= c_ONE;
            end else begin
                r_hp_cnt  <= w_hp_cnt_inc;
            end
            if (i_vs_rise)
                r_line_cnt <= '0;
            else if (i_de_fall)
                r_line_cnt <= w_line_cnt_inc;
            if (i_vs_rise) begin
                r_h_active <= r_h_line;
                r_v_active <= r_line_cnt;
            end
        end
    end

    assign o_match      = (r_h_line == r_h_active) && (r_line_cnt == r_v_active) &&
                          (r_line_cnt != '0);
    assign o_h_active   = r_h_active;
    assign o_v_active   = r_v_active;
    assign o_h_total    = r_h_total;
    assign o_meas_valid = r_meas_valid;

endmodule
`default_nettype wire

// File: rtl/tfp401a_rx_lock.sv
`default_nettype none
// ============================================================================
// tfp401a_rx_lock: 2-stage TMDS receiver bus register with geometry lock FSM.
// Optional macro SYNC_POL_AUTO_EN: detect and normalise sync polarity.
// Revision: 1.0
// ============================================================================
module tfp401a_rx_lock
    import tfp401a_pkg::*;
#(
    parameter int CH_NUM      = 3,
    parameter int CH_W        = 8,
    parameter int CNT_W       = 20,
    parameter int ACQ_WIN     = ACQ_WIN_DEFAULT,
    parameter int HOLD_WIN    = HOLD_WIN_DEFAULT,
    parameter int MEAS_W      = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                     odck_in,
    input  logic                     rst,
    input  logic                     vsync_in,
    input  logic                     hsync_in,
    input  logic                     de_in,
    input  logic [CH_NUM*CH_W-1:0]   pixel_in,
    output logic                     vsync_o,
    output logic                     hsync_o,
    output logic                     de_o,
    output logic [CH_NUM*CH_W-1:0]   pixel_o,
    output logic                     scdt_o,
    output logic [MEAS_W-1:0]        h_active_o,
    output logic [MEAS_W-1:0]        v_active_o,
    output logic [MEAS_W-1:0]        h_total_o,
    output logic                     meas_valid_o,
    output logic                     hsync_pol_o,
    output logic                     vsync_pol_o
);
    localparam int PX_W = CH_NUM * CH_W;
`ifdef SYNC_POL_AUTO_EN
    localparam logic c_POL_AUTO = 1'b1;
`else
    localparam logic c_POL_AUTO = 1'b0;
`endif

    logic             r_de_d1, r_vs_d1, r_hs_d1, r_de_d2, r_vs_d2, r_hs_d2;
    logic [PX_W-1:0]  r_px_d1, r_px_d2;
    logic             r_hs_pol, r_vs_pol, r_scdt;
    logic             w_hs_n, w_vs_n, w_de_rise, w_de_fall, w_vs_rise, w_match;
    logic [1:0]       r_state, w_state_nxt, r_tr_cnt;
    logic [2:0]       r_match_cnt, w_match_nxt, w_match_inc;
    logic [CNT_W-1:0] r_win;
    logic             w_win_term;

    // Polarity registers stay 0 when auto-detect is compiled out, so the XOR is a pass-through.
    assign w_hs_n    = r_hs_d1 ^ r_hs_pol;
    assign w_vs_n    = r_vs_d1 ^ r_vs_pol;
    assign w_de_rise = r_de_d1 & ~r_de_d2;
    assign w_de_fall = ~r_de_d1 & r_de_d2;
    assign w_vs_rise = w_vs_n & ~r_vs_d2;

    always_ff @(posedge odck_in) begin
        if (!rst) begin
            {r_de_d1, r_vs_d1, r_hs_d1, r_de_d2, r_vs_d2, r_hs_d2} <= '0;
            r_px_d1  <= '0;
            r_px_d2  <= '0;
            r_hs_pol <= 1'b0;
            r_vs_pol <= 1'b0;
        end else begin
            r_de_d1 <= de_in;
            r_vs_d1 <= vsync_in;
            r_hs_d1 <= hsync_in;
            r_px_d1 <= pixel_in;
            r_de_d2 <= r_de_d1;
            r_vs_d2 <= w_vs_n;
            r_hs_d2 <= w_hs_n;
            r_px_d2 <= r_px_d1;
            if (c_POL_AUTO && w_de_rise) begin
                r_hs_pol <= r_hs_d1;
                r_vs_pol <= r_vs_d1;
            end
        end
    end

    video_geom_meas #(.MEAS_W(MEAS_W)) u_geom (
        .clk          (odck_in),
        .rst          (rst),
        .i_de         (r_de_d1),
        .i_de_rise    (w_de_rise),
        .i_de_fall    (w_de_fall),
        .i_vs_rise    (w_vs_rise),
        .o_h_active   (h_active_o),
        .o_v_active   (v_active_o),
        .o_h_total    (h_total_o),
        .o_meas_valid (meas_valid_o),
        .o_match      (w_match)
    );

    assign w_win_term  = (r_state == LOST) ? (r_win == CNT_W'(ACQ_WIN - 1))
                                           : (r_win == CNT_W'(HOLD_WIN - 1));
    assign w_match_inc = r_match_cnt + 3'd1;

    // Timeout is tested before vs_rise so a coincident frame end cannot hold off LOST.
    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = 3'd0;
        case (r_state)
            LOST: begin
                if (w_win_term && r_tr_cnt == 2'd2)
                    w_state_nxt = ACQ;
            end
            ACQ: begin
                w_match_nxt = r_match_cnt;
                if (w_win_term && r_tr_cnt == 2'd0) begin
                    w_state_nxt = LOST;
                    w_match_nxt = 3'd0;
                end else if (w_vs_rise) begin
                    if (!w_match)
                        w_match_nxt = 3'd0;
                    else if (w_match_inc >= 3'(LOCK_FRAMES)) begin
                        w_state_nxt = LOCKED;
                        w_match_nxt = 3'd0;
                    end else
                        w_match_nxt = w_match_inc;
                end
            end
            LOCKED: begin
                if (w_win_term && r_tr_cnt == 2'd0)
                    w_state_nxt = LOST;
                else if (w_vs_rise && !w_match)
                    w_state_nxt = ACQ;
            end
            default: w_state_nxt = LOST;
        endcase
    end

    always_ff @(posedge odck_in) begin
        if (!rst) begin
            r_state     <= LOST;
            r_match_cnt <= 3'd0;
            r_win       <= '0;
            r_tr_cnt    <= 2'd0;
            r_scdt      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_scdt      <= (r_state == LOCKED);
            if (w_state_nxt != r_state || w_win_term)
                r_win <= '0;
            else
                r_win <= r_win + 1'b1;
            if (w_win_term)
                r_tr_cnt <= 2'd0;
            else if ((w_de_rise || w_de_fall) && r_tr_cnt != 2'd2)
                r_tr_cnt <= r_tr_cnt + 2'd1;
        end
    end

    assign de_o        = r_de_d2;
    assign vsync_o     = r_vs_d2;
    assign hsync_o     = r_hs_d2;
    assign pixel_o     = r_px_d2;
    assign scdt_o      = r_scdt;
    assign hsync_pol_o = r_hs_pol;
    assign vsync_pol_o = r_vs_pol;

endmodule
`default_nettype wire
